// File: rtl/uart_tx_report.sv
// rtl/uart_tx_report.sv - 8N1 UART transmitter for the config readback packet
// Packet: HEADER, payload byte 0..CONF_PAR_MAX-1, 8-bit sum of the payload.
module uart_tx_report #(
    parameter int         CONF_PAR_MAX  = 4,
    parameter int         FRAME_CNT_MAX = 5208,
    parameter logic [7:0] HEADER        = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CONF_PAR_MAX*8-1:0] par_in,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);

    localparam int CW  = $clog2(FRAME_CNT_MAX);
    localparam int BIW = $clog2(CONF_PAR_MAX + 2);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FRAME_CNT_MAX - 1);
    localparam logic [BIW-1:0] LAST_PAY = BIW'(CONF_PAR_MAX);
    localparam logic [BIW-1:0] LAST_IDX = BIW'(CONF_PAR_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP_BIT
    } state_t;

    state_t                    r_state, w_state_next;
    logic [CW-1:0]             r_cnt, w_cnt_next;
    logic [2:0]                r_bit_idx, w_bit_idx_next;
    logic [BIW-1:0]            r_byte_idx, w_byte_idx_next;
    logic [7:0]                r_shift, w_shift_next;
    logic [7:0]                r_chk, w_chk_next;
    logic [CONF_PAR_MAX*8-1:0] r_snap, w_snap_next;
    logic                      r_tx, w_tx_next;
    logic                      r_busy, w_busy_next;
    logic                      r_done, w_done_next;
    logic                      w_bit_end;
    logic [7:0]                w_pay_byte;

    assign w_bit_end  = (r_cnt == CNT_LAST);
    // Byte index k selects payload byte k as the byte following index k.
    assign w_pay_byte = 8'(r_snap >> {r_byte_idx, 3'b000});

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = w_bit_end ? '0 : r_cnt + 1'b1;
        w_bit_idx_next  = r_bit_idx;
        w_byte_idx_next = r_byte_idx;
        w_shift_next    = r_shift;
        w_chk_next      = r_chk;
        w_snap_next     = r_snap;
        w_done_next     = 1'b0;
        w_tx_next       = 1'b1;
        w_busy_next     = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (start) begin
                    w_state_next    = START_BIT;
                    w_snap_next     = par_in;
                    w_shift_next    = HEADER;
                    w_byte_idx_next = '0;
                    w_bit_idx_next  = '0;
                    w_chk_next      = '0;
                end
            end
            START_BIT: begin
                if (w_bit_end) begin
                    w_state_next   = DATA;
                    w_bit_idx_next = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP_BIT;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                        w_shift_next   = {1'b0, r_shift[7:1]};
                    end
                end
            end
            STOP_BIT: begin
                if (w_bit_end) begin
                    if (r_byte_idx == LAST_IDX) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next    = START_BIT;
                        w_byte_idx_next = r_byte_idx + 1'b1;
                        if (r_byte_idx == LAST_PAY) begin
                            w_shift_next = r_chk;
                        end else begin
                            w_shift_next = w_pay_byte;
                            w_chk_next   = r_chk + w_pay_byte;
                        end
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Line level is registered from the state being entered.
        case (w_state_next)
            START_BIT: w_tx_next = 1'b0;
            DATA:      w_tx_next = w_shift_next[0];
            default:   w_tx_next = 1'b1;
        endcase
        w_busy_next = (w_state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_chk      <= '0;
            r_snap     <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
            r_byte_idx <= w_byte_idx_next;
            r_shift    <= w_shift_next;
            r_chk      <= w_chk_next;
            r_snap     <= w_snap_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_uart_tx_report.sv
// tb/tb_uart_tx_report.sv - directed-vector bench for uart_tx_report
module tb_uart_tx_report;

    logic        clk = 1'b0;
    logic        rst_a, start_a, tx_a, busy_a, done_a;
    logic [15:0] par_a;
    logic        rst_b, start_b, tx_b, busy_b, done_b;
    logic [31:0] par_b;
    logic        rst_c, start_c, tx_c, busy_c, done_c;
    logic [31:0] par_c;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_report #(.CONF_PAR_MAX(2), .FRAME_CNT_MAX(4)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .par_in(par_a),
        .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    uart_tx_report u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .par_in(par_b),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    uart_tx_report #(.CONF_PAR_MAX(4), .FRAME_CNT_MAX(2)) u_dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .par_in(par_c),
        .tx(tx_c), .busy(busy_c), .done(done_c)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    function automatic logic cur_tx(input int which);
        return (which == 1) ? tx_c : tx_a;
    endfunction

    function automatic logic cur_done(input int which);
        return (which == 1) ? done_c : done_a;
    endfunction

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 1) start_c = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        if (which == 1) start_c = 1'b0; else start_a = 1'b0;
    endtask

    task automatic rx_byte(input int which, output logic [7:0] b);
        int per;
        int w;
        per = (which == 1) ? 2 : 4;
        w   = 0;
        b   = 8'h00;
        while (cur_tx(which) !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            chk("rx_start_timeout", 64'(w), 64'd0);
            return;
        end
        repeat (per / 2) @(negedge clk);
        chk("rx_start_bit", 64'(cur_tx(which)), 64'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (per) @(negedge clk);
            b[i] = cur_tx(which);
        end
        repeat (per) @(negedge clk);
        chk("rx_stop_bit", 64'(cur_tx(which)), 64'd1);
    endtask

    task automatic rx_packet(input int which, input logic [47:0] exp, input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            rx_byte(which, b);
            chk($sformatf("rx_byte%0d", i), 64'(b), 64'(exp[8*i +: 8]));
        end
    endtask

    task automatic wait_done(input int which);
        int w;
        w = 0;
        while (cur_done(which) !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("done_pulse", 64'(cur_done(which)), 64'd1);
        @(negedge clk);
        chk("done_one_cycle", 64'(cur_done(which)), 64'd0);
    endtask

    initial begin
        logic [31:0] pk_a;
        logic        exp_tx;
        int          n_done, n_idle, n_txbad, first_done, r, n_busy;
        int          exp_e[7];
        int          ne;
        logic        prev;
        logic [7:0]  rxb;

        pk_a  = 32'h1503_12A5;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b1; start_b = 1'b0; start_c = 1'b0;
        par_a = 16'h0312; par_b = 32'h0403_0201; par_c = 32'h0403_0201;
        repeat (3) @(negedge clk);
        chk("rst_tx", 64'(tx_a), 64'd1);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_tx_b", 64'(tx_b), 64'd1);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; start_a = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy_a), 64'd0);

        // 1: exact cycle trace of A5,12,03,15
        par_a = 16'h0312;
        pulse(0);
        for (int k = 1; k <= 162; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= 160) begin
                exp_tx = frame_bit(pk_a[8*((k-1)/40) +: 8], ((k-1) % 40) / 4);
                chk("t1_tx", 64'(tx_a), 64'(exp_tx));
                chk("t1_busy", 64'(busy_a), 64'd1);
                chk("t1_done", 64'(done_a), 64'd0);
            end else begin
                chk("t1_tx_end", 64'(tx_a), 64'd1);
                chk("t1_busy_end", 64'(busy_a), 64'd0);
                chk("t1_done_end", 64'(done_a), (k == 161) ? 64'd1 : 64'd0);
            end
        end

        // 2: checksum wrap
        par_a = 16'hFFFF;
        pulse(0);
        rx_packet(0, 48'h0000_FEFF_FFA5, 4);
        wait_done(0);

        // 3: start held high, back-to-back packets
        par_a = 16'h0312;
        @(negedge clk);
        start_a = 1'b1;
        n_done = 0; n_idle = 0; n_txbad = 0; first_done = 0;
        for (int k = 1; k <= 330; k++) begin
            @(negedge clk);
            r = k % 161;
            exp_tx = (r == 0) ? 1'b1 : frame_bit(pk_a[8*((r-1)/40) +: 8], ((r-1) % 40) / 4);
            if (tx_a !== exp_tx) n_txbad++;
            if (done_a === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = k;
            end
            if (busy_a !== 1'b1) n_idle++;
        end
        start_a = 1'b0;
        chk("t3_tx_errors", 64'(n_txbad), 64'd0);
        chk("t3_done_count", 64'(n_done), 64'd2);
        chk("t3_first_done", 64'(first_done), 64'd161);
        chk("t3_idle_cycles", 64'(n_idle), 64'd2);
        wait_done(0);

        pulse(0);
        n_done = 0; n_busy = 0;
        for (int k = 2; k <= 200; k++) begin
            @(negedge clk);
            if (k == 50 || k == 100) start_a = 1'b1;
            if (k == 51 || k == 101) start_a = 1'b0;
            if (done_a === 1'b1) n_done++;
            if (k >= 161 && busy_a !== 1'b0) n_busy++;
        end
        chk("t3_ignored_done", 64'(n_done), 64'd1);
        chk("t3_ignored_busy", 64'(n_busy), 64'd0);

        // 4: par_in changes after acceptance
        par_a = 16'h0312;
        pulse(0);
        par_a = 16'h5555;
        rx_packet(0, 48'h0000_1503_12A5, 4);
        wait_done(0);
        pulse(0);
        rx_packet(0, 48'h0000_AA55_55A5, 4);
        wait_done(0);

        // 5: reset mid-payload
        par_a = 16'h0312;
        pulse(0);
        repeat (69) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("t5_tx", 64'(tx_a), 64'd1);
        chk("t5_busy", 64'(busy_a), 64'd0);
        n_done = 0; n_busy = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done_a !== 1'b0) n_done++;
            if (busy_a !== 1'b0) n_busy++;
        end
        chk("t5_no_done", 64'(n_done), 64'd0);
        chk("t5_no_busy", 64'(n_busy), 64'd0);
        pulse(0);
        rx_packet(0, 48'h0000_1503_12A5, 4);
        wait_done(0);

        // four payload bytes at a short bit period
        pulse(1);
        rx_packet(1, 48'h0A04_0302_01A5, 6);
        wait_done(1);

        // 6: default parameters, bit period on every edge of the header byte
        exp_e = '{1, 2, 3, 4, 6, 7, 8};
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("t6_start_tx", 64'(tx_b), 64'd0);
        chk("t6_start_busy", 64'(busy_b), 64'd1);
        prev = tx_b;
        ne   = 0;
        rxb  = 8'h00;
        for (int c = 2; c <= 46873; c++) begin
            @(negedge clk);
            if (tx_b !== prev) begin
                if (ne < 7) chk("t6_edge", 64'(c), 64'(1 + exp_e[ne] * 5208));
                else        chk("t6_extra_edge", 64'(c), 64'd0);
                ne++;
                prev = tx_b;
            end
            if ((c - 1) % 5208 == 2604 && (c - 1) / 5208 >= 1) rxb[(c - 1) / 5208 - 1] = tx_b;
        end
        chk("t6_edge_count", 64'(ne), 64'd7);
        chk("t6_header", 64'(rxb), 64'hA5);
        chk("t6_busy", 64'(busy_b), 64'd1);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk("t6_rst_tx", 64'(tx_b), 64'd1);
        chk("t6_rst_busy", 64'(busy_b), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
